// File: rtl/crc16_frame_pkg.sv
// Shared types, constants and the CRC16 word-update function for the frame appender.
// The CRC16_FRAME_LEN_EN macro (used in crc16_frame_appender) adds a word count to the trailer.
package crc16_frame_pkg;

  localparam int DATA_W = 64;
  localparam int CRC_W  = 16;

  localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
  // x^16 + x^15 + x^2 + 1, MSB-first, data bit 63 enters first
  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;

  typedef enum logic {
    PASS  = 1'b0,
    TRAIL = 1'b1
  } state_e;

  function automatic logic [CRC_W-1:0] crc16_update(input logic [CRC_W-1:0]  crc,
                                                    input logic [DATA_W-1:0] data);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = crc;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ data[i];
      c  = {c[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_frame_appender_crc.sv
// crc16_64b_parallel: CRC16 engine absorbing one 64-bit word per enabled cycle.
// Synchronous active-high rst returns the register to CRC_INIT.
module crc16_64b_parallel
  import crc16_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              crc_en,
  input  logic [DATA_W-1:0] data_in,
  output logic [CRC_W-1:0]  crc_out
);

  logic [CRC_W-1:0] crc_q, crc_d;

  always_comb begin
    // NOTE: default assigned first so no path leaves crc_d unassigned (no latch).
    crc_d = crc_q;
    if (crc_en) crc_d = crc16_update(crc_q, data_in);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every register samples pre-edge values.
    if (rst) crc_q <= CRC_INIT;
    else     crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/crc16_frame_appender.sv
// Passes 64-bit frame words through a one-deep output register and appends a CRC16 trailer word.
// Define CRC16_FRAME_LEN_EN to place a saturating frame word count in trailer[31:16].
module crc16_frame_appender
  import crc16_frame_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic              frame_done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              frame_done_q, frame_done_d;
  logic [DATA_W-1:0] trailer;
  logic [CRC_W-1:0]  crc_val;
  logic              out_free, in_xfer, crc_reinit, crc_rst;

  // The output register can take a new word when empty or draining this cycle.
  assign out_free = !m_valid_q || m_ready;
  assign s_ready  = (state_q == PASS) && out_free;
  assign in_xfer  = s_valid && s_ready;
  assign crc_rst  = rst || crc_reinit;

  crc16_64b_parallel u_crc (
    .clk     (clk),
    .rst     (crc_rst),
    .crc_en  (in_xfer),
    .data_in (s_data),
    .crc_out (crc_val)
  );

`ifdef CRC16_FRAME_LEN_EN
  logic [CRC_W-1:0] word_cnt_q, word_cnt_d;

  always_comb begin
    word_cnt_d = word_cnt_q;
    if (in_xfer && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (crc_rst) word_cnt_q <= '0;
    else         word_cnt_q <= word_cnt_d;
  end

  assign trailer = {{(DATA_W - 2*CRC_W){1'b0}}, word_cnt_q, crc_val};
`else
  assign trailer = {{(DATA_W - CRC_W){1'b0}}, crc_val};
`endif

  always_comb begin
    state_d      = state_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    crc_reinit   = 1'b0;
    frame_done_d = m_valid_q && m_ready && m_last_q;

    unique case (state_q)
      PASS: begin
        if (in_xfer) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          m_last_d  = 1'b0;
          if (s_last) state_d = TRAIL;
        end else if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
        end
      end
      TRAIL: begin
        // Trailer captures the final CRC while the same edge re-initialises the engine.
        if (out_free) begin
          m_data_d   = trailer;
          m_valid_d  = 1'b1;
          m_last_d   = 1'b1;
          crc_reinit = 1'b1;
          state_d    = PASS;
        end
      end
      default: state_d = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= PASS;
      m_data_q     <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign m_data     = m_data_q;
  assign m_valid    = m_valid_q;
  assign m_last     = m_last_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_crc16_frame_appender.sv
// Self-checking bench for crc16_frame_appender: directed cases, then random frames against a
// long-division CRC model. Honours CRC16_FRAME_LEN_EN for the expected trailer layout.
module tb_crc16_frame_appender;

  typedef logic [63:0] word_q_t [$];
  localparam int N_FRAMES = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid, s_last, s_ready;
  logic [63:0] m_data;
  logic        m_valid, m_last, m_ready;
  logic        frame_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q[$];
  logic [64:0] mon_q[$];
  bit          mon_en   = 1'b0;
  int          done_cnt = 0;

  crc16_frame_appender dut (
    .clk        (clk),
    .rst        (rst),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Reference CRC: augmented polynomial long division of the frame bitstream, with the
  // 16'hFFFF preset applied by inverting the first 16 message bits.
  function automatic logic [15:0] ref_crc(input word_q_t ws);
    bit          msg[$];
    logic [16:0] rem;
    foreach (ws[w]) for (int b = 63; b >= 0; b--) msg.push_back(ws[w][b]);
    for (int i = 0; i < 16; i++) msg[i] = ~msg[i];
    for (int i = 0; i < 16; i++) msg.push_back(1'b0);
    rem = '0;
    foreach (msg[i]) begin
      rem = {rem[15:0], msg[i]};
      if (rem[16]) rem = rem ^ 17'h18005;
    end
    return rem[15:0];
  endfunction

  function automatic logic [63:0] exp_trailer(input word_q_t ws);
`ifdef CRC16_FRAME_LEN_EN
    logic [15:0] cnt;
    cnt = (ws.size() > 65535) ? 16'hFFFF : 16'(ws.size());
    return {32'h0, cnt, ref_crc(ws)};
`else
    return {48'h0, ref_crc(ws)};
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (m_valid && m_ready) mon_q.push_back({m_last, m_data});
      if (frame_done) done_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    word_q_t     zero_frame;
    word_q_t     ab_frame;
    word_q_t     words;
    logic [63:0] a_word, b_word;
    int          len, waited;
    bit          accepted;

    zero_frame = {};
    zero_frame.push_back(64'h0);

    // Reset: two cycles of rst
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 64'h0);
    check("rst_s_ready", s_ready, 1'b1);
    check("rst_frame_done", frame_done, 1'b0);

    // Single zero word frame
    s_data = 64'h0; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
    #1;
    check("single_s_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    check("single_word_valid", m_valid, 1'b1);
    check("single_word_data", m_data, 64'h0);
    check("single_word_last", m_last, 1'b0);
    check("single_bubble_s_ready", s_ready, 1'b0);
    tick();
    check("single_trl_last", m_last, 1'b1);
    check("single_trl_crc", m_data[15:0], 16'h02D0);
    check("single_trl_data", m_data, exp_trailer(zero_frame));
    check("single_done_early", frame_done, 1'b0);
    tick();
    check("single_done", frame_done, 1'b1);
    check("single_idle_valid", m_valid, 1'b0);
    tick();
    check("single_done_clear", frame_done, 1'b0);

    // Backpressure: word A pending, word B offered, m_ready low for 5 cycles
    a_word = {$urandom, $urandom};
    b_word = {$urandom, $urandom};
    ab_frame = {};
    ab_frame.push_back(a_word);
    ab_frame.push_back(b_word);
    s_data = a_word; s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b0;
    tick();
    s_data = b_word; s_last = 1'b1;
    #1;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_data%0d", i), m_data, a_word);
      check($sformatf("bp_s_ready%0d", i), s_ready, 1'b0);
      tick();
    end
    m_ready = 1'b1;
    #1;
    check("bp_release_s_ready", s_ready, 1'b1);
    tick();
    s_valid = 1'b0;
    check("bp_word_b", m_data, b_word);
    check("bp_word_b_last", m_last, 1'b0);
    tick();
    check("bp_trl_data", m_data, exp_trailer(ab_frame));
    check("bp_trl_last", m_last, 1'b1);
    m_ready = 1'b0;
    tick();
    check("bp_trl_hold", m_data, exp_trailer(ab_frame));
    check("bp_trl_hold_done", frame_done, 1'b0);
    m_ready = 1'b1;
    tick();
    check("bp_done", frame_done, 1'b1);
    check("bp_idle_valid", m_valid, 1'b0);
    tick();

    // Back-to-back single zero-word frames
    s_data = 64'h0; s_valid = 1'b1; s_last = 1'b1; m_ready = 1'b1;
    tick();
    #1;
    check("b2b_bubble", s_ready, 1'b0);
    tick();
    check("b2b_trl1_last", m_last, 1'b1);
    check("b2b_trl1_crc", m_data[15:0], 16'h02D0);
    tick();
    s_valid = 1'b0;
    check("b2b_word2", m_data, 64'h0);
    check("b2b_word2_last", m_last, 1'b0);
    check("b2b_done1", frame_done, 1'b1);
    tick();
    check("b2b_trl2_last", m_last, 1'b1);
    check("b2b_trl2_crc", m_data[15:0], 16'h02D0);
    check("b2b_trl2_data", m_data, exp_trailer(zero_frame));
    tick();
    check("b2b_done2", frame_done, 1'b1);
    tick();

    // Reset after 3 of 5 words discards the frame
    for (int i = 0; i < 3; i++) begin
      s_data = {$urandom, $urandom}; s_valid = 1'b1; s_last = 1'b0;
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", m_valid, 1'b0);
    check("mid_rst_data", m_data, 64'h0);
    check("mid_rst_last", m_last, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_rst_no_trl%0d", i), m_valid, 1'b0);
    end
    s_data = 64'h0; s_valid = 1'b1; s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    check("post_rst_word", m_data, 64'h0);
    check("post_rst_word_last", m_last, 1'b0);
    tick();
    check("post_rst_trl_last", m_last, 1'b1);
    check("post_rst_trl_crc", m_data[15:0], 16'h02D0);
    check("post_rst_trl_data", m_data, exp_trailer(zero_frame));
    tick();
    tick();

    // Random frames with input bubbles and random backpressure
    exp_q    = {};
    mon_q    = {};
    done_cnt = 0;
    mon_en   = 1'b1;
    for (int f = 0; f < N_FRAMES; f++) begin
      len   = $urandom_range(1, 6);
      words = {};
      for (int w = 0; w < len; w++) words.push_back({$urandom, $urandom});
      for (int w = 0; w < len; w++) exp_q.push_back({1'b0, words[w]});
      exp_q.push_back({1'b1, exp_trailer(words)});
      for (int w = 0; w < len; w++) begin
        repeat ($urandom_range(0, 1)) begin
          s_valid = 1'b0;
          m_ready = ($urandom_range(0, 2) != 0);
          tick();
        end
        s_valid  = 1'b1;
        s_data   = words[w];
        s_last   = (w == len - 1);
        accepted = 1'b0;
        waited   = 0;
        while (!accepted && waited < 100) begin
          m_ready = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          accepted = s_valid && s_ready;
          tick();
          waited++;
        end
        check($sformatf("rnd_accept_f%0d_w%0d", f, w), accepted, 1'b1);
      end
      s_valid = 1'b0;
    end
    m_ready = 1'b1;
    waited  = 0;
    while (mon_q.size() < exp_q.size() && waited < 200) begin
      tick();
      waited++;
    end
    tick();
    tick();
    mon_en = 1'b0;
    check("rnd_beat_count", mon_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < mon_q.size(); i++) begin
      check($sformatf("rnd_beat%0d_data", i), mon_q[i][63:0], exp_q[i][63:0]);
      check($sformatf("rnd_beat%0d_last", i), mon_q[i][64], exp_q[i][64]);
    end
    check("rnd_frame_done_count", done_cnt, N_FRAMES);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/crc16_frame_appender.md
CRC16_FRAME_APPENDER -- requirements
Module: crc16_frame_appender

Interface
REQ-001 SHALL have no parameters; data width is fixed at 64 bits and CRC width at 16 bits.
REQ-002 clk  in  1  sole clock; all logic on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 s_data  in  64  upstream frame word.
REQ-005 s_valid  in  1  s_data valid.
REQ-006 s_last  in  1  s_data is final word of frame.
REQ-007 s_ready  out  1  block accepts s_data this cycle.
REQ-008 m_data  out  64  downstream word (payload or trailer).
REQ-009 m_valid  out  1  m_data valid.
REQ-010 m_last  out  1  m_data is the CRC trailer word.
REQ-011 m_ready  in  1  downstream accepts m_data.
REQ-012 frame_done  out  1  one-cycle pulse, registered, the cycle after a trailer transfer.

Function
REQ-013 SHALL have two states, PASS and TRAIL; reset state is PASS.
REQ-014 s_ready SHALL equal (state==PASS) && (!m_valid || m_ready); it is combinational and never depends on s_valid.
REQ-015 An input transfer (s_valid && s_ready) SHALL load m_data<=s_data, m_valid<=1, m_last<=0 at that edge; latency is 1 cycle.
REQ-016 Each input transfer SHALL assert crc_en to the CRC sub-module with data_in=s_data in the same cycle.
REQ-017 An input transfer with s_last=1 SHALL move the state PASS->TRAIL.
REQ-018 In TRAIL, when (!m_valid || m_ready), SHALL load m_data<=trailer, m_valid<=1, m_last<=1, pulse CRC re-init, and return to PASS.
REQ-019 trailer[15:0] SHALL be the CRC register value (init 16'hFFFF, poly x^16+x^15+x^2+1, 64 bits per update) after the frame's last word.
REQ-020 In PASS, when m_valid && m_ready and no input transfer occurs, m_valid SHALL clear to 0 on that edge.
REQ-021 While m_valid && !m_ready, m_data, m_valid and m_last SHALL hold unchanged.
REQ-022 The CRC re-init pulse SHALL drive the sub-module rst together with block rst, so the next frame starts from 16'hFFFF; the trailer captures the pre-init value on the same edge.
REQ-023 Frames SHALL contain 1 or more words; one input bubble (TRAIL cycle) per frame is permitted; back-to-back frames SHALL need no idle gap beyond it.
REQ-024 s_valid held low mid-frame SHALL leave the state and CRC unchanged.

Reset
REQ-025 On rst: state=PASS, m_data=64'h0, m_valid=0, m_last=0, frame_done=0, CRC=16'hFFFF, word counter=0.
REQ-026 rst mid-frame SHALL discard the partial frame; no trailer is emitted for it.

Configuration
REQ-027 Macro CRC16_FRAME_LEN_EN defined: trailer[31:16] SHALL be the frame's data-word count (saturating at 16'hFFFF, cleared at re-init) and trailer[63:32]=0.
REQ-028 Macro CRC16_FRAME_LEN_EN undefined: no counter logic; trailer[63:16]=0.

Structure
REQ-029 Package crc16_frame_pkg SHALL hold the state typedef (PASS, TRAIL), CRC_INIT=16'hFFFF, DATA_W=64, CRC_W=16.
REQ-030 SHALL instantiate exactly one sub-module, the existing crc16_64b_parallel engine, for the CRC; no CRC equations are duplicated in this block.

Verification
REQ-031 Reset: assert rst 2 cycles -> m_valid=0, m_last=0, m_data=0, s_ready=1, frame_done=0.
REQ-032 Single word 64'h0, s_last=1, m_ready=1 -> cycle+1 m_data=0 with m_last=0; cycle+2 m_data[15:0]=16'h02D0 with m_last=1 ([31:16]=16'h0001 if CRC16_FRAME_LEN_EN); frame_done at cycle+3.
REQ-033 Backpressure: m_ready=0 for 5 cycles with a word pending -> m_data stable, s_ready=0 throughout; m_ready=1 -> word then trailer delivered in order.
REQ-034 Two back-to-back single-zero-word frames -> both trailers have CRC 16'h02D0, which proves re-init.
REQ-035 rst asserted after 3 of 5 words -> no trailer emitted; a following single 64'h0 frame yields CRC 16'h02D0.
